// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC_SEL encodings, fetch FSM states and instruction width.
package cpu_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_SEL_W = 2;

  typedef enum logic [PC_SEL_W-1:0] {
    PCSEL_INC    = 2'b00,
    PCSEL_BR_REL = 2'b01,
    PCSEL_BR_REG = 2'b10,
    PCSEL_HOLD   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_WAIT  = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC selection for the fetch unit; forces word alignment and flags misaligned targets.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  pc_sel_e           pc_sel,
  input  logic [ADDR_W-1:0] br_offset,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misalign_hit
);

  logic [ADDR_W-1:0] target;

  always_comb begin
    target = pc;
    unique case (pc_sel)
      PCSEL_INC:    target = pc + ADDR_W'(4);
      PCSEL_BR_REL: target = pc + br_offset;
      PCSEL_BR_REG: target = reg_target;
      PCSEL_HOLD:   target = pc;
      default:      target = pc;
    endcase

    // Hold keeps PC exactly; every computed target is word-aligned on the way in.
    if (pc_sel == PCSEL_HOLD) begin
      next_pc      = pc;
      misalign_hit = 1'b0;
    end else begin
      next_pc      = {target[ADDR_W-1:2], 2'b00};
      misalign_hit = (target[1:0] != 2'b00);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR, issues reads on the shared RAM bus and hands a stable Inst to the CU.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       WAIT_MAX = 15
) (
  input  logic               clock,
  input  logic               Reset,
  input  logic               IL,
  input  logic [1:0]         PC_SEL,
  input  logic [ADDR_W-1:0]  br_offset,
  input  logic [ADDR_W-1:0]  reg_target,
  input  logic [INST_W-1:0]  mem_rdata,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               EN_ADDR_PC,
  output logic               RCS,
  output logic               RR,
  output logic [INST_W-1:0]  Inst,
  output logic               inst_valid,
  output logic [ADDR_W-1:0]  PC,
  output logic               misalign
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  fetch_state_e      state_q,      state_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic [INST_W-1:0] inst_q,       inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic              misalign_q,   misalign_d;
  logic              bus_q,        bus_d;
  logic [ADDR_W-1:0] mem_addr_q,   mem_addr_d;
  logic [CNT_W-1:0]  wait_cnt_q,   wait_cnt_d;

  logic [CNT_W-1:0]  wait_inc;
  logic [ADDR_W-1:0] next_pc;
  logic              misalign_hit;

  pc_next_calc #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_calc (
    .pc           (pc_q),
    .pc_sel       (pc_sel_e'(PC_SEL)),
    .br_offset    (br_offset),
    .reg_target   (reg_target),
    .next_pc      (next_pc),
    .misalign_hit (misalign_hit)
  );

  assign wait_inc = wait_cnt_q + CNT_W'(1);

  // Bus strobes are registered, so they are high during WAIT and low while FETCH sets up.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    misalign_d   = misalign_q;
    wait_cnt_d   = wait_cnt_q;
    bus_d        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        bus_d      = 1'b1;
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready) begin
          inst_d       = mem_rdata;
          inst_valid_d = 1'b1;
          wait_cnt_d   = '0;
          state_d      = S_EXEC;
        end else if (wait_inc == CNT_W'(WAIT_MAX)) begin
          wait_cnt_d = '0;
          state_d    = S_FETCH;
        end else begin
          wait_cnt_d = wait_inc;
          bus_d      = 1'b1;
        end
      end
      S_EXEC: begin
        if (IL) begin
          inst_valid_d = 1'b0;
          pc_d         = next_pc;
          misalign_d   = misalign_q | misalign_hit;
          state_d      = (PC_SEL == PCSEL_HOLD) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        inst_valid_d = 1'b0;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    mem_addr_d = bus_d ? pc_q : '0;
  end

  always_ff @(posedge clock) begin
    if (Reset) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_q        <= 1'b0;
      mem_addr_q   <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misalign_q   <= misalign_d;
      bus_q        <= bus_d;
      mem_addr_q   <= mem_addr_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign EN_ADDR_PC = bus_q;
  assign RCS        = bus_q;
  assign RR         = bus_q;
  assign Inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign PC         = pc_q;
  assign misalign   = misalign_q;

endmodule
